// File: rtl/rs_multi_if.sv
// Bus bundle between dispatch / CDB / issue lanes / LSQ and the reservation station.
// The station itself uses the slave view; the producer/consumer side uses master.
interface rs_multi_if #(
  parameter int RS_SIZE   = 16,
  parameter int DISP_W    = 2,
  parameter int ISS_W     = 2,
  parameter int CDB_W     = 2,
  parameter int PRF_BITS  = 6,
  parameter int ARF_BITS  = 5,
  parameter int PAYLOAD_W = 64
);
  localparam int CNT_W = $clog2(RS_SIZE + 1);

  logic [DISP_W-1:0]           disp_valid;
  logic [DISP_W*PAYLOAD_W-1:0] disp_payload;
  logic [DISP_W-1:0]           disp_is_ld;
  logic [DISP_W-1:0]           disp_is_st;
  logic [DISP_W*ARF_BITS-1:0]  disp_rs1;
  logic [DISP_W*ARF_BITS-1:0]  disp_rs2;
  logic [DISP_W*ARF_BITS-1:0]  disp_rd;
  logic [DISP_W*PRF_BITS-1:0]  disp_t1;
  logic [DISP_W*PRF_BITS-1:0]  disp_t2;
  logic [DISP_W*PRF_BITS-1:0]  disp_t;
  logic [DISP_W-1:0]           disp_r1;
  logic [DISP_W-1:0]           disp_r2;
  logic [DISP_W-1:0]           disp_stall;
  logic [CNT_W-1:0]            free_cnt;

  logic [CDB_W-1:0]            cdb_valid;
  logic [CDB_W*PRF_BITS-1:0]   cdb_tag;

  logic [ISS_W-1:0]            iss_valid;
  logic [ISS_W-1:0]            iss_ready;
  logic [ISS_W*PAYLOAD_W-1:0]  iss_payload;
  logic [ISS_W*PRF_BITS-1:0]   iss_t;
  logic [ISS_W*PRF_BITS-1:0]   iss_t1;
  logic [ISS_W*PRF_BITS-1:0]   iss_t2;

  logic                        perm_req_valid;
  logic [PRF_BITS-1:0]         perm_req_tag;
  logic                        perm_req_ready;
  logic                        perm_grant_valid;
  logic [PRF_BITS-1:0]         perm_grant_tag;

  modport master (
    output disp_valid, disp_payload, disp_is_ld, disp_is_st,
           disp_rs1, disp_rs2, disp_rd, disp_t1, disp_t2, disp_t, disp_r1, disp_r2,
           cdb_valid, cdb_tag, iss_ready, perm_req_ready, perm_grant_valid, perm_grant_tag,
    input  disp_stall, free_cnt, iss_valid, iss_payload, iss_t, iss_t1, iss_t2,
           perm_req_valid, perm_req_tag
  );

  modport slave (
    input  disp_valid, disp_payload, disp_is_ld, disp_is_st,
           disp_rs1, disp_rs2, disp_rd, disp_t1, disp_t2, disp_t, disp_r1, disp_r2,
           cdb_valid, cdb_tag, iss_ready, perm_req_ready, perm_grant_valid, perm_grant_tag,
    output disp_stall, free_cnt, iss_valid, iss_payload, iss_t, iss_t1, iss_t2,
           perm_req_valid, perm_req_tag
  );
endinterface

// File: rtl/rs_multi.sv
// Multi-wide reservation station: dispatch with intra-bundle rename bypass,
// CDB wakeup, oldest-first issue with a memory-port cap, and LSQ load permits.
module rs_multi #(
  parameter int RS_SIZE   = 16,
  parameter int DISP_W    = 2,
  parameter int ISS_W     = 2,
  parameter int CDB_W     = 2,
  parameter int PRF_BITS  = 6,
  parameter int ARF_BITS  = 5,
  parameter int PAYLOAD_W = 64,
  parameter int AGE_W     = 8,
  parameter int MEM_PORTS = 1
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      flush,
  rs_multi_if.slave bus
);
  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam int CNT_W = $clog2(RS_SIZE + 1);

  // Wrap-safe age order; in-flight span stays below half the counter range.
  function automatic logic older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
    logic [AGE_W-1:0] d;
    d = a - b;
    return d[AGE_W-1];
  endfunction

  function automatic logic cdb_hit(input logic [PRF_BITS-1:0] tag,
                                   input logic [CDB_W-1:0] v,
                                   input logic [CDB_W*PRF_BITS-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < CDB_W; c++)
      if (v[c] && tags[c*PRF_BITS +: PRF_BITS] == tag) hit = 1'b1;
    return hit;
  endfunction

  logic [RS_SIZE-1:0]   valid_q, r1_q, r2_q, is_ld_q, is_st_q, permit_q, req_sent_q;
  logic [PAYLOAD_W-1:0] payload_q [RS_SIZE];
  logic [PRF_BITS-1:0]  t_q [RS_SIZE];
  logic [PRF_BITS-1:0]  t1_q [RS_SIZE];
  logic [PRF_BITS-1:0]  t2_q [RS_SIZE];
  logic [AGE_W-1:0]     age_q [RS_SIZE];
  logic [AGE_W-1:0]     age_ctr_q;

  logic [CNT_W-1:0]  n_valid, free_cnt_c;
  logic [DISP_W-1:0] stall_c;

  // Free count from registered occupancy; forced to zero (all lanes stalled) while in reset.
  always_comb begin
    n_valid = '0;
    for (int i = 0; i < RS_SIZE; i++) n_valid = n_valid + CNT_W'(valid_q[i]);
    free_cnt_c = reset ? (CNT_W'(RS_SIZE) - n_valid) : '0;
    stall_c = '0;
    for (int k = 0; k < DISP_W; k++) stall_c[k] = (free_cnt_c <= CNT_W'(k));
  end

  assign bus.free_cnt   = free_cnt_c;
  assign bus.disp_stall = stall_c;

  logic [DISP_W-1:0]  disp_we;
  logic [IDX_W-1:0]   alloc_idx [DISP_W];
  logic [AGE_W-1:0]   disp_age [DISP_W];
  logic [AGE_W-1:0]   age_ctr_d;
  logic [RS_SIZE-1:0] claimed;
  logic               found;

  // Lane k takes the lowest free slot not already claimed by a lower lane; ages are consecutive.
  always_comb begin
    claimed   = '0;
    age_ctr_d = age_ctr_q;
    found     = 1'b0;
    for (int k = 0; k < DISP_W; k++) begin
      disp_we[k]   = 1'b0;
      alloc_idx[k] = '0;
      disp_age[k]  = age_ctr_d;
      found        = 1'b0;
      for (int i = 0; i < RS_SIZE; i++) begin
        if (!found && !valid_q[i] && !claimed[i]) begin
          found        = 1'b1;
          alloc_idx[k] = IDX_W'(i);
        end
      end
      if (bus.disp_valid[k] && !stall_c[k] && !flush && found) begin
        disp_we[k]              = 1'b1;
        claimed[alloc_idx[k]]   = 1'b1;
        age_ctr_d               = age_ctr_d + AGE_W'(1);
      end
    end
  end

  logic [PRF_BITS-1:0] src1_tag [DISP_W];
  logic [PRF_BITS-1:0] src2_tag [DISP_W];
  logic [DISP_W-1:0]   src1_rdy, src2_rdy;

  // Source operands: map-table values, overridden by older same-bundle producers, then CDB wakeup.
  always_comb begin
    src1_tag = '{default: '0};
    src2_tag = '{default: '0};
    src1_rdy = '0;
    src2_rdy = '0;
    for (int k = 0; k < DISP_W; k++) begin
      src1_tag[k] = bus.disp_t1[k*PRF_BITS +: PRF_BITS];
      src2_tag[k] = bus.disp_t2[k*PRF_BITS +: PRF_BITS];
      src1_rdy[k] = bus.disp_r1[k];
      src2_rdy[k] = bus.disp_r2[k];
      for (int j = 0; j < DISP_W; j++) begin
        if (j < k && bus.disp_valid[j]) begin
          if (bus.disp_rs1[k*ARF_BITS +: ARF_BITS] != '0 &&
              bus.disp_rd[j*ARF_BITS +: ARF_BITS] == bus.disp_rs1[k*ARF_BITS +: ARF_BITS]) begin
            src1_tag[k] = bus.disp_t[j*PRF_BITS +: PRF_BITS];
            src1_rdy[k] = 1'b0;
          end
          if (bus.disp_rs2[k*ARF_BITS +: ARF_BITS] != '0 &&
              bus.disp_rd[j*ARF_BITS +: ARF_BITS] == bus.disp_rs2[k*ARF_BITS +: ARF_BITS]) begin
            src2_tag[k] = bus.disp_t[j*PRF_BITS +: PRF_BITS];
            src2_rdy[k] = 1'b0;
          end
        end
      end
      if (cdb_hit(src1_tag[k], bus.cdb_valid, bus.cdb_tag)) src1_rdy[k] = 1'b1;
      if (cdb_hit(src2_tag[k], bus.cdb_valid, bus.cdb_tag)) src2_rdy[k] = 1'b1;
    end
  end

  logic [RS_SIZE-1:0] elig, taken;
  logic [ISS_W-1:0]   iss_v;
  logic [IDX_W-1:0]   iss_idx [ISS_W];
  int                 mem_used;

  // Oldest-first pick per lane; memory ops past the port cap are passed over.
  always_comb begin
    taken    = '0;
    mem_used = 0;
    iss_v    = '0;
    iss_idx  = '{default: '0};
    for (int i = 0; i < RS_SIZE; i++)
      elig[i] = valid_q[i] & r1_q[i] & r2_q[i] & (~is_ld_q[i] | permit_q[i]);
    for (int l = 0; l < ISS_W; l++) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (elig[i] && !taken[i] && !((is_ld_q[i] || is_st_q[i]) && mem_used >= MEM_PORTS)) begin
          if (!iss_v[l] || older(age_q[i], age_q[iss_idx[l]])) begin
            iss_v[l]   = 1'b1;
            iss_idx[l] = IDX_W'(i);
          end
        end
      end
      if (iss_v[l]) begin
        taken[iss_idx[l]] = 1'b1;
        if (is_ld_q[iss_idx[l]] || is_st_q[iss_idx[l]]) mem_used = mem_used + 1;
      end
    end
  end

  // Issue lane outputs, zeroed when the lane is idle.
  always_comb begin
    bus.iss_valid   = iss_v;
    bus.iss_payload = '0;
    bus.iss_t       = '0;
    bus.iss_t1      = '0;
    bus.iss_t2      = '0;
    for (int l = 0; l < ISS_W; l++) begin
      if (iss_v[l]) begin
        bus.iss_payload[l*PAYLOAD_W +: PAYLOAD_W] = payload_q[iss_idx[l]];
        bus.iss_t[l*PRF_BITS +: PRF_BITS]         = t_q[iss_idx[l]];
        bus.iss_t1[l*PRF_BITS +: PRF_BITS]        = t1_q[iss_idx[l]];
        bus.iss_t2[l*PRF_BITS +: PRF_BITS]        = t2_q[iss_idx[l]];
      end
    end
  end

  logic             perm_v;
  logic [IDX_W-1:0] perm_idx;

  // Oldest load still waiting for a permit and not yet requested.
  always_comb begin
    perm_v   = 1'b0;
    perm_idx = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (valid_q[i] && is_ld_q[i] && !permit_q[i] && !req_sent_q[i]) begin
        if (!perm_v || older(age_q[i], age_q[perm_idx])) begin
          perm_v   = 1'b1;
          perm_idx = IDX_W'(i);
        end
      end
    end
  end

  assign bus.perm_req_valid = perm_v;
  assign bus.perm_req_tag   = perm_v ? t_q[perm_idx] : '0;

  // Entry state: flush beats wakeup/grant/issue/dispatch; dispatch writes only free slots.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      r1_q       <= '0;
      r2_q       <= '0;
      is_ld_q    <= '0;
      is_st_q    <= '0;
      permit_q   <= '0;
      req_sent_q <= '0;
      age_ctr_q  <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        payload_q[i] <= '0;
        t_q[i]       <= '0;
        t1_q[i]      <= '0;
        t2_q[i]      <= '0;
        age_q[i]     <= '0;
      end
    end else if (flush) begin
      valid_q    <= '0;
      permit_q   <= '0;
      req_sent_q <= '0;
      age_ctr_q  <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (valid_q[i]) begin
          if (cdb_hit(t1_q[i], bus.cdb_valid, bus.cdb_tag)) r1_q[i] <= 1'b1;
          if (cdb_hit(t2_q[i], bus.cdb_valid, bus.cdb_tag)) r2_q[i] <= 1'b1;
          if (is_ld_q[i] && bus.perm_grant_valid && t_q[i] == bus.perm_grant_tag)
            permit_q[i] <= 1'b1;
        end
      end
      if (perm_v && bus.perm_req_ready) req_sent_q[perm_idx] <= 1'b1;
      for (int l = 0; l < ISS_W; l++)
        if (iss_v[l] && bus.iss_ready[l]) valid_q[iss_idx[l]] <= 1'b0;
      for (int k = 0; k < DISP_W; k++) begin
        if (disp_we[k]) begin
          valid_q[alloc_idx[k]]    <= 1'b1;
          payload_q[alloc_idx[k]]  <= bus.disp_payload[k*PAYLOAD_W +: PAYLOAD_W];
          is_ld_q[alloc_idx[k]]    <= bus.disp_is_ld[k];
          is_st_q[alloc_idx[k]]    <= bus.disp_is_st[k];
          t_q[alloc_idx[k]]        <= bus.disp_t[k*PRF_BITS +: PRF_BITS];
          t1_q[alloc_idx[k]]       <= src1_tag[k];
          t2_q[alloc_idx[k]]       <= src2_tag[k];
          r1_q[alloc_idx[k]]       <= src1_rdy[k];
          r2_q[alloc_idx[k]]       <= src2_rdy[k];
          permit_q[alloc_idx[k]]   <= 1'b0;
          req_sent_q[alloc_idx[k]] <= 1'b0;
          age_q[alloc_idx[k]]      <= disp_age[k];
        end
      end
      age_ctr_q <= age_ctr_d;
    end
  end
endmodule

// File: tb/tb_rs_multi.sv
// Directed bench for rs_multi: a table of fill/stall vectors plus hand-written
// sequences for bypass, load permits, age wrap, same-cycle wakeup, flush and reset.
module tb_rs_multi;
  localparam int PW = 64;
  localparam int TW = 6;
  localparam int AW = 5;

  logic clock;
  logic reset;
  logic flush;
  int   errors;
  int   checks;

  rs_multi_if #(.RS_SIZE(16), .DISP_W(2), .ISS_W(2), .CDB_W(2),
                .PRF_BITS(TW), .ARF_BITS(AW), .PAYLOAD_W(PW)) bus ();

  rs_multi #(.RS_SIZE(16), .DISP_W(2), .ISS_W(2), .CDB_W(2), .PRF_BITS(TW),
             .ARF_BITS(AW), .PAYLOAD_W(PW), .AGE_W(8), .MEM_PORTS(1)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] dv;
    logic [4:0] exp_free;
    logic [1:0] exp_stall;
  } vec_t;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    bus.disp_valid = '0; bus.disp_payload = '0; bus.disp_is_ld = '0; bus.disp_is_st = '0;
    bus.disp_rs1 = '0; bus.disp_rs2 = '0; bus.disp_rd = '0;
    bus.disp_t1 = '0; bus.disp_t2 = '0; bus.disp_t = '0; bus.disp_r1 = '0; bus.disp_r2 = '0;
    bus.cdb_valid = '0; bus.cdb_tag = '0; bus.iss_ready = '0;
    bus.perm_req_ready = 1'b0; bus.perm_grant_valid = 1'b0; bus.perm_grant_tag = '0;
    flush = 1'b0;
  endtask

  task automatic set_lane(input int k, input logic [63:0] pl, input logic ld,
                          input logic [4:0] rs1, input logic [4:0] rd,
                          input logic [5:0] t1, input logic [5:0] t, input logic r1);
    bus.disp_valid[k]            = 1'b1;
    bus.disp_payload[k*PW +: PW] = pl;
    bus.disp_is_ld[k]            = ld;
    bus.disp_is_st[k]            = 1'b0;
    bus.disp_rs1[k*AW +: AW]     = rs1;
    bus.disp_rs2[k*AW +: AW]     = '0;
    bus.disp_rd[k*AW +: AW]      = rd;
    bus.disp_t1[k*TW +: TW]      = t1;
    bus.disp_t2[k*TW +: TW]      = '0;
    bus.disp_t[k*TW +: TW]       = t;
    bus.disp_r1[k]               = r1;
    bus.disp_r2[k]               = 1'b1;
  endtask

  task automatic alu(input int k, input logic [63:0] pl, input logic [5:0] t1, input logic r1);
    set_lane(k, pl, 1'b0, 5'd0, 5'd0, t1, 6'd0, r1);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] pl0();
    return bus.iss_payload[63:0];
  endfunction

  function automatic logic [63:0] pl1();
    return bus.iss_payload[127:64];
  endfunction

  vec_t vecs [9];

  initial begin
    errors = 0;
    checks = 0;
    vecs[0] = '{dv: 2'b11, exp_free: 5'd14, exp_stall: 2'b00};
    vecs[1] = '{dv: 2'b11, exp_free: 5'd12, exp_stall: 2'b00};
    vecs[2] = '{dv: 2'b11, exp_free: 5'd10, exp_stall: 2'b00};
    vecs[3] = '{dv: 2'b11, exp_free: 5'd8,  exp_stall: 2'b00};
    vecs[4] = '{dv: 2'b11, exp_free: 5'd6,  exp_stall: 2'b00};
    vecs[5] = '{dv: 2'b11, exp_free: 5'd4,  exp_stall: 2'b00};
    vecs[6] = '{dv: 2'b11, exp_free: 5'd2,  exp_stall: 2'b00};
    vecs[7] = '{dv: 2'b11, exp_free: 5'd0,  exp_stall: 2'b11};
    vecs[8] = '{dv: 2'b11, exp_free: 5'd0,  exp_stall: 2'b11};

    clr();
    reset = 1'b0;
    #2;
    chk("rst_free", 64'(bus.free_cnt), 64'd0);
    chk("rst_stall", 64'(bus.disp_stall), 64'b11);
    chk("rst_iss_valid", 64'(bus.iss_valid), 64'd0);
    chk("rst_perm", 64'(bus.perm_req_valid), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_free", 64'(bus.free_cnt), 64'd16);

    // Intra-bundle bypass: lane1 rs1 reads lane0 rd.
    clr();
    set_lane(0, 64'hA0, 1'b0, 5'd0, 5'd3, 6'd0, 6'd20, 1'b1);
    set_lane(1, 64'hA1, 1'b0, 5'd3, 5'd4, 6'd7, 6'd21, 1'b1);
    tick();
    chk("byp_iss_valid", 64'(bus.iss_valid), 64'b01);
    chk("byp_pl0", pl0(), 64'hA0);
    chk("byp_free", 64'(bus.free_cnt), 64'd14);
    clr();
    bus.cdb_valid = 2'b01;
    bus.cdb_tag[5:0] = 6'd20;
    tick();
    chk("byp_wake_valid", 64'(bus.iss_valid), 64'b11);
    chk("byp_wake_pl0", pl0(), 64'hA0);
    chk("byp_wake_pl1", pl1(), 64'hA1);
    chk("byp_t1_lane1", 64'(bus.iss_t1[11:6]), 64'd20);
    chk("byp_t_lane0", 64'(bus.iss_t[5:0]), 64'd20);
    clr();
    bus.iss_ready = 2'b11;
    tick();
    chk("byp_drain_free", 64'(bus.free_cnt), 64'd16);
    chk("byp_drain_valid", 64'(bus.iss_valid), 64'd0);

    // Fill to full from the table; the last vector dispatches while stalled.
    for (int i = 0; i < 9; i++) begin
      clr();
      if (vecs[i].dv[0]) alu(0, 64'h100 + 64'(2*i), 6'(32 + 2*i), 1'b0);
      if (vecs[i].dv[1]) alu(1, 64'h101 + 64'(2*i), 6'(33 + 2*i), 1'b0);
      tick();
      chk($sformatf("fill%0d_free", i), 64'(bus.free_cnt), 64'(vecs[i].exp_free));
      chk($sformatf("fill%0d_stall", i), 64'(bus.disp_stall), 64'(vecs[i].exp_stall));
    end
    clr();
    bus.cdb_valid = 2'b10;
    bus.cdb_tag[11:6] = 6'd32;
    tick();
    chk("full_wake_valid", 64'(bus.iss_valid), 64'b01);
    chk("full_wake_pl0", pl0(), 64'h100);
    clr();
    bus.iss_ready = 2'b01;
    tick();
    chk("full_acc_free", 64'(bus.free_cnt), 64'd1);
    chk("full_acc_stall", 64'(bus.disp_stall), 64'b10);
    clr();
    flush = 1'b1;
    tick();
    clr();
    chk("flush1_free", 64'(bus.free_cnt), 64'd16);

    // Loads waiting on permits; one memory issue per cycle.
    clr();
    set_lane(0, 64'h200, 1'b1, 5'd0, 5'd0, 6'd0, 6'd40, 1'b1);
    set_lane(1, 64'h201, 1'b1, 5'd0, 5'd0, 6'd0, 6'd41, 1'b1);
    tick();
    chk("ld_req_valid", 64'(bus.perm_req_valid), 64'd1);
    chk("ld_req_tag", 64'(bus.perm_req_tag), 64'd40);
    chk("ld_no_issue", 64'(bus.iss_valid), 64'd0);
    clr();
    set_lane(0, 64'h202, 1'b0, 5'd0, 5'd0, 6'd0, 6'd42, 1'b1);
    tick();
    chk("ld_alu_valid", 64'(bus.iss_valid), 64'b01);
    chk("ld_alu_pl", pl0(), 64'h202);
    chk("ld_req_tag_b", 64'(bus.perm_req_tag), 64'd40);
    clr();
    bus.perm_req_ready = 1'b1;
    bus.iss_ready = 2'b01;
    tick();
    chk("ld_req2_tag", 64'(bus.perm_req_tag), 64'd41);
    chk("ld_none_ready", 64'(bus.iss_valid), 64'd0);
    clr();
    bus.perm_grant_valid = 1'b1;
    bus.perm_grant_tag = 6'd40;
    tick();
    chk("ld_grant_valid", 64'(bus.iss_valid), 64'b01);
    chk("ld_grant_pl", pl0(), 64'h200);
    chk("ld_req3_tag", 64'(bus.perm_req_tag), 64'd41);
    clr();
    bus.perm_req_ready = 1'b1;
    bus.perm_grant_valid = 1'b1;
    bus.perm_grant_tag = 6'd41;
    tick();
    chk("ld_memcap_valid", 64'(bus.iss_valid), 64'b01);
    chk("ld_memcap_pl", pl0(), 64'h200);
    chk("ld_req_done", 64'(bus.perm_req_valid), 64'd0);
    clr();
    bus.iss_ready = 2'b01;
    bus.perm_grant_valid = 1'b1;
    bus.perm_grant_tag = 6'd63;
    tick();
    chk("ld_second_valid", 64'(bus.iss_valid), 64'b01);
    chk("ld_second_pl", pl0(), 64'h201);
    clr();
    bus.iss_ready = 2'b01;
    tick();
    chk("ld_drain_free", 64'(bus.free_cnt), 64'd16);

    // Age wrap: run the age counter to 0xFE, then park four entries.
    clr();
    flush = 1'b1;
    tick();
    for (int c = 0; c < 127; c++) begin
      clr();
      alu(0, 64'h1000 + 64'(c), 6'd0, 1'b1);
      alu(1, 64'h2000 + 64'(c), 6'd0, 1'b1);
      bus.iss_ready = 2'b11;
      tick();
    end
    clr();
    bus.iss_ready = 2'b11;
    tick();
    tick();
    chk("wrap_bulk_free", 64'(bus.free_cnt), 64'd16);
    clr();
    alu(0, 64'h3FE, 6'd50, 1'b0);
    alu(1, 64'h3FF, 6'd60, 1'b0);
    tick();
    clr();
    alu(0, 64'h300, 6'd60, 1'b0);
    alu(1, 64'h301, 6'd50, 1'b0);
    tick();
    chk("wrap_idle", 64'(bus.iss_valid), 64'd0);
    clr();
    bus.cdb_valid = 2'b01;
    bus.cdb_tag[5:0] = 6'd50;
    tick();
    chk("wrap_valid", 64'(bus.iss_valid), 64'b11);
    chk("wrap_pl0", pl0(), 64'h3FE);
    chk("wrap_pl1", pl1(), 64'h301);
    clr();
    bus.iss_ready = 2'b01;
    tick();
    chk("wrap_acc_valid", 64'(bus.iss_valid), 64'b01);
    chk("wrap_acc_pl0", pl0(), 64'h301);
    for (int c = 0; c < 3; c++) begin
      clr();
      tick();
      chk($sformatf("hold%0d_valid", c), 64'(bus.iss_valid), 64'b01);
      chk($sformatf("hold%0d_pl0", c), pl0(), 64'h301);
    end
    clr();
    flush = 1'b1;
    tick();
    clr();
    chk("flush2_free", 64'(bus.free_cnt), 64'd16);

    // Same-cycle CDB on dispatch, then flush with 6 valid.
    clr();
    set_lane(0, 64'h400, 1'b0, 5'd0, 5'd0, 6'd25, 6'd14, 1'b0);
    bus.cdb_valid = 2'b10;
    bus.cdb_tag[11:6] = 6'd25;
    tick();
    chk("samecyc_valid", 64'(bus.iss_valid), 64'b01);
    chk("samecyc_pl", pl0(), 64'h400);
    clr();
    alu(0, 64'h401, 6'd30, 1'b0);
    alu(1, 64'h402, 6'd31, 1'b0);
    tick();
    clr();
    alu(0, 64'h403, 6'd33, 1'b0);
    alu(1, 64'h404, 6'd34, 1'b0);
    tick();
    clr();
    alu(0, 64'h405, 6'd35, 1'b0);
    tick();
    chk("six_free", 64'(bus.free_cnt), 64'd10);
    clr();
    flush = 1'b1;
    alu(0, 64'h406, 6'd0, 1'b1);
    bus.iss_ready = 2'b01;
    tick();
    clr();
    chk("flush3_free", 64'(bus.free_cnt), 64'd16);
    chk("flush3_valid", 64'(bus.iss_valid), 64'd0);
    alu(0, 64'h407, 6'd0, 1'b1);
    tick();
    chk("postflush_valid", 64'(bus.iss_valid), 64'b01);
    chk("postflush_pl", pl0(), 64'h407);
    chk("postflush_free", 64'(bus.free_cnt), 64'd15);

    // Asynchronous reset with 5 entries live.
    clr();
    set_lane(0, 64'h500, 1'b1, 5'd0, 5'd0, 6'd1, 6'd44, 1'b0);
    alu(1, 64'h501, 6'd1, 1'b0);
    tick();
    clr();
    alu(0, 64'h502, 6'd2, 1'b0);
    alu(1, 64'h503, 6'd3, 1'b0);
    tick();
    clr();
    tick();
    chk("pre_rst_free", 64'(bus.free_cnt), 64'd11);
    chk("pre_rst_perm", 64'(bus.perm_req_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_free", 64'(bus.free_cnt), 64'd0);
    chk("mid_rst_stall", 64'(bus.disp_stall), 64'b11);
    chk("mid_rst_iss", 64'(bus.iss_valid), 64'd0);
    #1;
    reset = 1'b1;
    tick();
    chk("after_rst_free", 64'(bus.free_cnt), 64'd16);
    chk("after_rst_iss", 64'(bus.iss_valid), 64'd0);
    chk("after_rst_perm", 64'(bus.perm_req_valid), 64'd0);
    chk("after_rst_stall", 64'(bus.disp_stall), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rs_multi.md
Name: rs_multi

Overview:
- Parametrised reservation station for the out-of-order core; successor to the 2-wide RS.
- Sits between dispatch (after map table and free list) and the issue/execute lanes.
- Accepts up to DISP_W renamed instructions per cycle and snoops CDB_W completion tags for operand wakeup.
- Issues up to ISS_W ready instructions per cycle, oldest first, under a valid/ready handshake per lane.
- Manages load-permit requests to the LSQ and caps memory issues per cycle at MEM_PORTS.

Parameters:
- RS_SIZE, 16, number of entries.
- DISP_W, 2, dispatch lanes.
- ISS_W, 2, issue lanes.
- CDB_W, 2, completion broadcast lanes.
- PRF_BITS, 6, physical tag width.
- ARF_BITS, 5, architectural register index width; index 0 is the zero register.
- PAYLOAD_W, 64, opaque decoded-instruction payload width.
- AGE_W, 8, age sequence counter width.
- MEM_PORTS, 1, max memory ops issued per cycle.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  rollback; clears the station
- disp_valid  in  DISP_W  dispatch lane valid
- disp_payload  in  DISP_W*PAYLOAD_W  decoded packet
- disp_is_ld / disp_is_st  in  DISP_W each  memory op class
- disp_rs1 / disp_rs2 / disp_rd  in  DISP_W*ARF_BITS each  architectural indices
- disp_t1 / disp_t2 / disp_t  in  DISP_W*PRF_BITS each  source tags (map table) and dest tag (free list)
- disp_r1 / disp_r2  in  DISP_W each  source-ready bits from map table
- disp_stall  out  DISP_W  lane k may not dispatch
- free_cnt  out  $clog2(RS_SIZE+1)  free entries
- cdb_valid  in  CDB_W  completion valid
- cdb_tag  in  CDB_W*PRF_BITS  completed tag
- iss_valid  out  ISS_W  issue lane valid
- iss_ready  in  ISS_W  execute accepts
- iss_payload / iss_t / iss_t1 / iss_t2  out  per lane  issued packet and tags
- perm_req_valid  out  1  load-permit request
- perm_req_tag  out  PRF_BITS  dest tag of requesting load
- perm_req_ready  in  1  LSQ accepts request
- perm_grant_valid  in  1  LSQ grants permit
- perm_grant_tag  in  PRF_BITS  granted load's dest tag

Behaviour:
- Entry state:
  - valid, payload, t, t1, r1, t2, r2, is_ld, is_st, permit, req_sent, age.
  - Reset (reset low, async): all valid=0; age counter=0; all outputs 0 except disp_stall=all-ones and free_cnt=0 while in reset.
- Dispatch:
  - disp_stall[k]=1 iff free_cnt <= k (free_cnt counts the registered state).
  - Lane k writes the lowest-index free entry not claimed by lanes <k.
  - Age = age_ctr + (number of valid lanes below k); age_ctr advances by the popcount of written lanes.
- Intra-bundle bypass: if lane j<k has disp_rd[j]==disp_rs1[k] and rs1!=0, the source takes tag disp_t[j] and is not ready (latest such j wins). Same rule for rs2.
- Wakeup:
  - Any cdb_valid with cdb_tag==t1 on a valid entry sets r1 the same edge; likewise t2.
  - Also applies to entries being dispatched this cycle (after bypass): no lost wakeups.
- Issue eligibility: valid & r1 & r2 & (!is_ld | permit), evaluated on registered state. Same-cycle CDB does not make an entry issuable until the next cycle.
- Issue select:
  - Lane 0 gets the oldest eligible entry, lane 1 the next oldest, and so on.
  - Memory ops (ld or st) beyond MEM_PORTS in a cycle are skipped and the next eligible non-memory op is taken.
  - Age compare is wrap-safe: a older than b iff MSB of (a-b) mod 2^AGE_W is 1. In-flight span is always < 2^(AGE_W-1).
- Handshake:
  - Entry is freed at the edge where iss_valid&iss_ready for its lane.
  - If not accepted, the same entry is presented next cycle unless an older one becomes eligible. Iss outputs are combinational from state, zero when iss_valid=0.
  - A freed entry is reusable by dispatch the following cycle (no same-cycle reuse).
- Load permit:
  - perm_req_valid asserts for the oldest valid load with permit=0 and req_sent=0. req_sent is set on perm_req_valid&perm_req_ready.
  - perm_grant_valid with matching t on a valid load sets permit next edge. A grant for no matching entry is ignored.
  - Grant and request on the same cycle are both honoured.
- Flush: synchronous.
  - At the edge with flush=1, all valid=0, age_ctr=0, req_sent/permit cleared.
  - Dispatch, issue handshakes and grants that cycle are discarded.
  - Flush has priority over everything except reset.
- Full: free_cnt=0 → all disp_stall=1; dispatch while stalled is an upstream error and is ignored.

Test Plan:
- Reset low mid-traffic with 5 entries valid → next cycle free_cnt=16, iss_valid=0, perm_req_valid=0.
- Dispatch lane0 rd=3 t=20, lane1 rs1=3 with r1=1 → lane1 entry t1=20, r1=0; cdb_tag=20 next cycle → both issue in age order two cycles later.
- Fill 16 entries (8 cycles of 2) → disp_stall=2'b11, free_cnt=0; accept one issue → free_cnt=1, disp_stall=2'b10.
- Two ready loads plus one ALU op, MEM_PORTS=1, loads unpermitted → only ALU issues, perm_req_tag = older load; grant it → that load issues next cycle, other load requested.
- Ages 0xFE and 0x01 (wrap) both ready with iss_ready=01 → lane0 issues age 0xFE; iss_ready held 0 for lane0 → same entry re-presented each cycle.
- CDB matching tag on the same cycle as dispatch of a consumer with r1=0 → entry stored with r1=1 and issues next cycle; flush asserted with 6 valid → all cleared, next dispatch gets age 0.
